// File: rtl/cla192_pipe_add.sv
// Two-stage pipelined 192-bit adder built from three 64-bit lookahead groups.
// Stage 1 forms per-group partial sums with generate/propagate flags.
// Stage 2 resolves the group carries with lookahead equations and produces
// the final sum and carry-out. A valid/ready handshake lets stalls ripple back.
module cla192_pipe_add #(
  parameter int DATA_W = 192,
  parameter int GRP_W  = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic              c_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] sum,
  output logic              c_out
);

  // The carry equations below are written for exactly three groups.
  localparam int NGRP = 3;

  // ---------------- handshake ----------------
  logic s1_valid_q;
  logic s2_valid_q;
  logic s1_adv;
  logic s2_adv;

  // A stage may advance when it is empty or when the stage after it advances.
  // in_ready depends only on register state and out_ready, never on in_valid.
  assign s2_adv   = !s2_valid_q || out_ready;
  assign s1_adv   = !s1_valid_q || s2_adv;
  assign in_ready = s1_adv;

  // ---------------- stage 1: per-group sums and P/G ----------------
  logic [NGRP-1:0][GRP_W-1:0] s0_d;
  logic [NGRP-1:0]            g_d;
  logic [NGRP-1:0]            p_d;

  logic [NGRP-1:0][GRP_W-1:0] s0_q;
  logic [NGRP-1:0]            g_q;
  logic [NGRP-1:0]            p_q;
  logic                       cin_q;

  for (genvar gi = 0; gi < NGRP; gi++) begin : g_grp_s1
    logic [GRP_W:0]   grp_add;
    logic [GRP_W-1:0] a_slice;
    logic [GRP_W-1:0] b_slice;

    assign a_slice  = a[gi*GRP_W +: GRP_W];
    assign b_slice  = b[gi*GRP_W +: GRP_W];
    // Group add with carry-in 0; the extra MSB is the group generate.
    assign grp_add  = {1'b0, a_slice} + {1'b0, b_slice};
    assign s0_d[gi] = grp_add[GRP_W-1:0];
    assign g_d[gi]  = grp_add[GRP_W];
    // Propagate means the group sum is all ones, so a carry-in would pass through.
    assign p_d[gi]  = &(a_slice ^ b_slice);
  end

  // Stage-1 register: valid follows the input on advance, data loads only with a real beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s0_q       <= '0;
      g_q        <= '0;
      p_q        <= '0;
      cin_q      <= 1'b0;
    end else if (s1_adv) begin
      s1_valid_q <= in_valid;
      if (in_valid) begin
        s0_q  <= s0_d;
        g_q   <= g_d;
        p_q   <= p_d;
        cin_q <= c_in;
      end
    end
  end

  // ---------------- stage 2: carry lookahead and final sum ----------------
  logic [NGRP-1:0]   cy_d;
  logic              cout_d;
  logic [DATA_W-1:0] sum_d;
  logic [DATA_W-1:0] sum_q;
  logic              cout_q;

  // Inter-group carries from the registered generate/propagate flags.
  always_comb begin
    cy_d    = '0;
    cy_d[0] = cin_q;
    cy_d[1] = g_q[0] | (cin_q & p_q[0]);
    cy_d[2] = g_q[1] | (g_q[0] & p_q[1]) | (cin_q & p_q[0] & p_q[1]);
    cout_d  = g_q[2] | (cy_d[2] & p_q[2]);
  end

  for (genvar gi = 0; gi < NGRP; gi++) begin : g_grp_s2
    // Adding the group carry can only wrap when the partial sum is all ones,
    // and that case is already folded into the next group's carry via p.
    assign sum_d[gi*GRP_W +: GRP_W] = s0_q[gi] + {{(GRP_W-1){1'b0}}, cy_d[gi]};
  end

  // Stage-2 register: holds while stalled; bubbles clear valid but keep data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid_q <= 1'b0;
      sum_q      <= '0;
      cout_q     <= 1'b0;
    end else if (s2_adv) begin
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        sum_q  <= sum_d;
        cout_q <= cout_d;
      end
    end
  end

  assign out_valid = s2_valid_q;
  assign sum       = sum_q;
  assign c_out     = cout_q;

endmodule

// File: tb/tb_cla192_pipe_add.sv
// Testbench for cla192_pipe_add: directed corner cases followed by random
// streaming with random handshakes, scored against plain 193-bit arithmetic.
module tb_cla192_pipe_add;

  localparam int W = 192;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         c_in;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         c_out;

  int tests = 0;
  int fails = 0;
  int n_acc = 0;
  logic smp_ir;
  logic smp_ov;
  logic [W:0] exp_q[$];

  always #5 clk = ~clk;

  cla192_pipe_add #(.DATA_W(192), .GRP_W(64)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .c_in      (c_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .c_out     (c_out)
  );

  task automatic chk(input string tag, input logic [W:0] obs, input logic [W:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: the full unsigned sum, carry-out in bit W.
  function automatic logic [W:0] ref_add(input logic [W-1:0] x, input logic [W-1:0] y,
                                         input logic ci);
    return {1'b0, x} + {1'b0, y} + {{W{1'b0}}, ci};
  endfunction

  // Random operands, biased so groups often propagate or generate.
  task automatic gen_pair(output logic [W-1:0] x, output logic [W-1:0] y);
    logic [63:0] u;
    logic [63:0] v;
    for (int g = 0; g < 3; g++) begin
      u = {$urandom, $urandom};
      case ($urandom_range(0, 3))
        0: v = {$urandom, $urandom};
        1: v = ~u;
        2: begin u = '1; v = {$urandom, $urandom}; end
        default: begin u = '1; v = '0; end
      endcase
      x[g*64 +: 64] = u;
      y[g*64 +: 64] = v;
    end
  endtask

  // One clock cycle: drive inputs, score any drain, record any accept, advance.
  task automatic step(input logic v, input logic [W-1:0] aa, input logic [W-1:0] bb,
                      input logic ci, input logic ordy);
    in_valid  = v;
    a         = aa;
    b         = bb;
    c_in      = ci;
    out_ready = ordy;
    #1;
    smp_ir = in_ready;
    smp_ov = out_valid;
    chk("no_x", (W+1)'($isunknown({out_valid, in_ready, c_out, sum})), '0);
    if (out_valid && ordy) begin
      if (exp_q.size() == 0) chk("out_without_beat", (W+1)'(exp_q.size()), (W+1)'(1));
      else chk("result", {c_out, sum}, exp_q.pop_front());
    end
    if (v && in_ready) begin
      exp_q.push_back(ref_add(aa, bb, ci));
      n_acc++;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin : main
    logic [W-1:0] x, y, ones, zero, t1, t2, t3;
    logic [W-1:0] b1a, b1b, b2a, b2b, b3a, b3b;
    logic [W:0]   e1;
    int cyc;

    ones = '1;
    zero = '0;

    // ---- reset state ----
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; c_in = 1'b0;
    #12;
    chk("rst_out_valid", (W+1)'(out_valid), '0);
    chk("rst_sum_cout", {c_out, sum}, '0);
    chk("rst_in_ready", (W+1)'(in_ready), (W+1)'(1));
    @(negedge clk);
    rst_n = 1'b1;

    // ---- carry ripple across all groups ----
    step(1'b1, ones, zero, 1'b1, 1'b1);
    chk("ripple_lat1", (W+1)'(out_valid), '0);
    step(1'b0, zero, zero, 1'b0, 1'b1);
    chk("ripple_valid", (W+1)'(out_valid), (W+1)'(1));
    chk("ripple_sum", {c_out, sum}, {1'b1, {W{1'b0}}});
    step(1'b0, zero, zero, 1'b0, 1'b1);
    chk("ripple_one_beat", (W+1)'(out_valid), '0);

    // ---- group-boundary generate ----
    t1 = '0; t1[63:0] = '1;
    t2 = '0; t2[0] = 1'b1;
    step(1'b1, t1, t2, 1'b0, 1'b1);
    t1 = '0; t1[127:0] = '1;
    t2 = '0; t2[64] = 1'b1;
    step(1'b1, t1, t2, 1'b0, 1'b1);
    e1 = '0; e1[64] = 1'b1;
    chk("grp_gen0", {c_out, sum}, e1);
    step(1'b0, zero, zero, 1'b0, 1'b1);
    // (2^128 - 1) + 2^64 = 2^128 + 2^64 - 1
    e1 = '0; e1[128] = 1'b1; e1[63:0] = '1;
    chk("grp_gen1", {c_out, sum}, e1);
    step(1'b0, zero, zero, 1'b0, 1'b1);

    // ---- back-to-back streaming ----
    for (int i = 0; i < 100; i++) begin
      gen_pair(x, y);
      step(1'b1, x, y, 1'($urandom_range(0, 1)), 1'b1);
      chk("stream_in_ready", (W+1)'(smp_ir), (W+1)'(1));
      if (i >= 2) chk("stream_out_valid", (W+1)'(smp_ov), (W+1)'(1));
    end
    step(1'b0, zero, zero, 1'b0, 1'b1);
    step(1'b0, zero, zero, 1'b0, 1'b1);
    chk("stream_drained", (W+1)'(exp_q.size()), '0);

    // ---- backpressure ----
    gen_pair(b1a, b1b); gen_pair(b2a, b2b); gen_pair(b3a, b3b);
    step(1'b1, b1a, b1b, 1'b0, 1'b0);
    step(1'b1, b2a, b2b, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step(1'b1, b3a, b3b, 1'b1, 1'b0);
      chk("bp_in_ready", (W+1)'(smp_ir), '0);
      chk("bp_out_valid", (W+1)'(smp_ov), (W+1)'(1));
      chk("bp_hold", {c_out, sum}, ref_add(b1a, b1b, 1'b0));
    end
    chk("bp_third_refused", (W+1)'(exp_q.size()), (W+1)'(2));
    step(1'b1, b3a, b3b, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b0, zero, zero, 1'b0, 1'b1);
    chk("bp_drained", (W+1)'(exp_q.size()), '0);

    // ---- asynchronous reset mid-stream ----
    gen_pair(x, y);
    step(1'b1, x, y, 1'b1, 1'b1);
    gen_pair(x, y);
    step(1'b1, x, y, 1'b0, 1'b1);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_out_valid", (W+1)'(out_valid), '0);
    chk("arst_sum_cout", {c_out, sum}, '0);
    chk("arst_in_ready", (W+1)'(in_ready), (W+1)'(1));
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    t1 = W'(5); t2 = W'(7);
    step(1'b1, t1, t2, 1'b0, 1'b1);
    chk("post_rst_lat1", (W+1)'(out_valid), '0);
    step(1'b0, zero, zero, 1'b0, 1'b1);
    chk("post_rst_valid", (W+1)'(out_valid), (W+1)'(1));
    chk("post_rst_sum", {c_out, sum}, (W+1)'(12));
    step(1'b0, zero, zero, 1'b0, 1'b1);

    // ---- random traffic with random handshakes ----
    n_acc = 0;
    cyc = 0;
    while (n_acc < 10000 && cyc < 40000) begin
      gen_pair(t3, x);
      step(1'($urandom_range(0, 9) < 7), t3, x, 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 9) < 7));
      cyc++;
    end
    chk("rand_budget", (W+1)'(n_acc >= 10000), (W+1)'(1));
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) step(1'b0, zero, zero, 1'b0, 1'b1);
    chk("rand_drained", (W+1)'(exp_q.size()), '0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
